multicycle_control_fsm: RTL and testbench

Multi-cycle RV32I control unit that replaces the single-cycle opcode decoder in the datapath. It sequences each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It waits on instruction and data memory ready handshakes and traps illegal opcodes and memory timeouts. It also keeps a retired-instruction counter.

---
 rtl/multicycle_control_fsm.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer.
// Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
// Waits on the instruction and data memory ready handshakes. Traps on illegal
// opcodes and on memory waits that run too long. Counts retired instructions.
module multicycle_control_fsm #(
  parameter int unsigned OPCODE_SIZE = 7,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [OPCODE_SIZE-1:0] Opcode,
  input  logic                   ImemReady,
  input  logic                   DmemReady,
  input  logic                   BranchTaken,
  output logic [2:0]             ALUOp,
  output logic                   JumpReg,
  output logic                   Jump,
  output logic                   Branch,
  output logic                   RegSrc1,
  output logic                   RegSrc2,
  output logic                   UpperImm,
  output logic                   MemToReg,
  output logic                   RetAddr,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   RegWrite,
  output logic                   Trap,
  output logic [2:0]             State,
  output logic [CNT_WIDTH-1:0]   InstrRetired
);

  localparam logic [OPCODE_SIZE-1:0] OpRType = OPCODE_SIZE'(7'b0110011);
  localparam logic [OPCODE_SIZE-1:0] OpIAlu  = OPCODE_SIZE'(7'b0010011);
  localparam logic [OPCODE_SIZE-1:0] OpLoad  = OPCODE_SIZE'(7'b0000011);
  localparam logic [OPCODE_SIZE-1:0] OpStore = OPCODE_SIZE'(7'b0100011);
  localparam logic [OPCODE_SIZE-1:0] OpBr    = OPCODE_SIZE'(7'b1100011);
  localparam logic [OPCODE_SIZE-1:0] OpJalr  = OPCODE_SIZE'(7'b1100111);
  localparam logic [OPCODE_SIZE-1:0] OpJal   = OPCODE_SIZE'(7'b1101111);
  localparam logic [OPCODE_SIZE-1:0] OpLui   = OPCODE_SIZE'(7'b0110111);
  localparam logic [OPCODE_SIZE-1:0] OpAuipc = OPCODE_SIZE'(7'b0010111);

  // Wait count value at which a still-low ready turns into a trap on this edge.
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
  } state_e;

  // Instruction class, only as fine as the sequencing needs.
  typedef enum logic [1:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBranch
  } cls_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       jump_reg;
    logic       jump;
    logic       branch;
    logic       reg_src1;
    logic       reg_src2;
    logic       upper_imm;
    logic       mem_to_reg;
    logic       ret_addr;
  } sel_t;

  state_e               state_q, state_d;
  cls_e                 cls_q, cls_d;
  sel_t                 sel_q, sel_d;
  logic [7:0]           wait_q, wait_d;
  logic                 trap_q, trap_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 ir_write_q, ir_write_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic                 reg_write_q, reg_write_d;
  logic                 pc_write_q, pc_write_d;

  sel_t                 dec_sel;
  cls_e                 dec_cls;
  logic                 dec_legal;
  logic                 retire;
  logic                 pc_now;

  // Opcode to select set; only consumed on the DECODE exit edge.
  always_comb begin
    dec_sel   = '0;
    dec_cls   = ClsAlu;
    dec_legal = 1'b1;
    case (Opcode)
      OpRType: begin
        dec_sel.alu_op = 3'b010;
      end
      OpIAlu: begin
        dec_sel.alu_op   = 3'b011;
        dec_sel.reg_src2 = 1'b1;
      end
      OpLoad: begin
        dec_sel.alu_op     = 3'b000;
        dec_sel.reg_src2   = 1'b1;
        dec_sel.mem_to_reg = 1'b1;
        dec_cls            = ClsLoad;
      end
      OpStore: begin
        dec_sel.alu_op   = 3'b000;
        dec_sel.reg_src2 = 1'b1;
        dec_cls          = ClsStore;
      end
      OpBr: begin
        dec_sel.alu_op = 3'b001;
        dec_sel.branch = 1'b1;
        dec_cls        = ClsBranch;
      end
      OpJalr: begin
        dec_sel.jump_reg = 1'b1;
        dec_sel.ret_addr = 1'b1;
        dec_sel.reg_src2 = 1'b1;
      end
      OpJal: begin
        dec_sel.jump     = 1'b1;
        dec_sel.ret_addr = 1'b1;
      end
      OpLui: begin
        dec_sel.upper_imm = 1'b1;
        dec_sel.alu_op    = 3'b100;
      end
      OpAuipc: begin
        dec_sel.upper_imm = 1'b1;
        dec_sel.reg_src1  = 1'b1;
        dec_sel.alu_op    = 3'b101;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // Next state, wait counter, retire event and next registered outputs.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    sel_d   = sel_q;
    wait_d  = wait_q;
    trap_d  = trap_q;
    retire  = 1'b0;
    pc_now  = 1'b0;

    case (state_q)
      StFetch: begin
        if (ImemReady) begin
          state_d = StDecode;
        end else if (wait_q == WaitLast) begin
          state_d = StTrap;
          trap_d  = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        if (dec_legal) begin
          state_d = StExecute;
          sel_d   = dec_sel;
          cls_d   = dec_cls;
        end else begin
          // Selects keep the last legal instruction's values.
          state_d = StTrap;
          trap_d  = 1'b1;
        end
      end
      StExecute: begin
        case (cls_q)
          ClsLoad, ClsStore: state_d = StMemory;
          ClsBranch: begin
            state_d = StFetch;
            retire  = 1'b1;
            pc_now  = BranchTaken;
          end
          default: state_d = StWriteback;
        endcase
      end
      StMemory: begin
        if (DmemReady) begin
          if (cls_q == ClsStore) begin
            state_d = StFetch;
            retire  = 1'b1;
            pc_now  = 1'b1;
          end else begin
            state_d = StWriteback;
          end
        end else if (wait_q == WaitLast) begin
          state_d = StTrap;
          trap_d  = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWriteback: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StTrap;
        trap_d  = 1'b1;
      end
    endcase

    // Every state entry restarts the wait count; only FETCH/MEMORY ever use it.
    if (state_d != state_q) begin
      wait_d = '0;
    end

    // A reset cycle abandons the access, so no PC update may escape it.
    pc_now = pc_now & reset_n;

    retired_d = retired_q + CNT_WIDTH'(retire);

    // Moore strobes: decided from the state being entered, high for that state.
    ir_write_d  = (state_d == StDecode);
    mem_read_d  = (state_d == StFetch) || ((state_d == StMemory) && (cls_d == ClsLoad));
    mem_write_d = (state_d == StMemory) && (cls_d == ClsStore);
    reg_write_d = (state_d == StWriteback);
    pc_write_d  = (state_d == StWriteback);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StFetch;
      cls_q       <= ClsAlu;
      sel_q       <= '0;
      wait_q      <= '0;
      trap_q      <= 1'b0;
      retired_q   <= '0;
      ir_write_q  <= 1'b0;
      mem_read_q  <= 1'b1;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      sel_q       <= sel_d;
      wait_q      <= wait_d;
      trap_q      <= trap_d;
      retired_q   <= retired_d;
      ir_write_q  <= ir_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      pc_write_q  <= pc_write_d;
    end
  end

  assign State        = state_q;
  assign ALUOp        = sel_q.alu_op;
  assign JumpReg      = sel_q.jump_reg;
  assign Jump         = sel_q.jump;
  assign Branch       = sel_q.branch;
  assign RegSrc1      = sel_q.reg_src1;
  assign RegSrc2      = sel_q.reg_src2;
  assign UpperImm     = sel_q.upper_imm;
  assign MemToReg     = sel_q.mem_to_reg;
  assign RetAddr      = sel_q.ret_addr;
  assign IRWrite      = ir_write_q;
  assign MemRead      = mem_read_q;
  assign MemWrite     = mem_write_q;
  assign RegWrite     = reg_write_q;
  assign Trap         = trap_q;
  assign InstrRetired = retired_q;
  // Branch-taken and store-complete updates depend on inputs seen this cycle.
  assign PCWrite      = pc_write_q | pc_now;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed vector table,
// hand-written corner sequences and a randomized instruction stream checked
// against a per-instruction trace model.
module tb_multicycle_control_fsm;

  localparam int unsigned CW = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [6:0]    Opcode;
  logic          ImemReady, DmemReady, BranchTaken;
  logic [2:0]    ALUOp;
  logic          JumpReg, Jump, Branch, RegSrc1, RegSrc2, UpperImm, MemToReg, RetAddr;
  logic          IRWrite, PCWrite, MemRead, MemWrite, RegWrite, Trap;
  logic [2:0]    State;
  logic [CW-1:0] InstrRetired;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .OPCODE_SIZE(7),
    .MEM_TIMEOUT(15),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .Opcode      (Opcode),
    .ImemReady   (ImemReady),
    .DmemReady   (DmemReady),
    .BranchTaken (BranchTaken),
    .ALUOp       (ALUOp),
    .JumpReg     (JumpReg),
    .Jump        (Jump),
    .Branch      (Branch),
    .RegSrc1     (RegSrc1),
    .RegSrc2     (RegSrc2),
    .UpperImm    (UpperImm),
    .MemToReg    (MemToReg),
    .RetAddr     (RetAddr),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .Trap        (Trap),
    .State       (State),
    .InstrRetired(InstrRetired)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: selects of the last decoded legal instruction, trap flag, retire count.
  logic [10:0]   m_sel;
  logic          m_trap;
  logic [CW-1:0] m_cnt;

  typedef struct {
    logic [6:0] op;
    logic       ir, dr, bt;
    logic [2:0] st;
    logic       irw, pcw, mr, mw, rw;
    logic [3:0] cnt;
    logic [2:0] alu;
    logic       m2r;
  } vec_t;

  vec_t       tbl [23];
  logic [6:0] ops [9];

  // {legal, ALUOp, JumpReg, Jump, Branch, RegSrc1, RegSrc2, UpperImm, MemToReg, RetAddr}
  function automatic logic [11:0] dec(input logic [6:0] op);
    case (op)
      OP_R:     return {1'b1, 3'b010, 8'b0000_0000};
      OP_I:     return {1'b1, 3'b011, 8'b0000_1000};
      OP_LD:    return {1'b1, 3'b000, 8'b0000_1010};
      OP_ST:    return {1'b1, 3'b000, 8'b0000_1000};
      OP_BR:    return {1'b1, 3'b001, 8'b0010_0000};
      OP_JALR:  return {1'b1, 3'b000, 8'b1000_1001};
      OP_JAL:   return {1'b1, 3'b000, 8'b0100_0001};
      OP_LUI:   return {1'b1, 3'b100, 8'b0000_0100};
      OP_AUIPC: return {1'b1, 3'b101, 8'b0001_0100};
      default:  return 12'h000;
    endcase
  endfunction

  function automatic vec_t mk(input logic [6:0] op, input int ir, dr, bt, st, irw, pcw, mr, mw,
                              rw, cnt, alu, m2r);
    vec_t v;
    v.op  = op;
    v.ir  = 1'(ir);
    v.dr  = 1'(dr);
    v.bt  = 1'(bt);
    v.st  = 3'(st);
    v.irw = 1'(irw);
    v.pcw = 1'(pcw);
    v.mr  = 1'(mr);
    v.mw  = 1'(mw);
    v.rw  = 1'(rw);
    v.cnt = 4'(cnt);
    v.alu = 3'(alu);
    v.m2r = 1'(m2r);
    return v;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic int pick_delay();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 14));
    return int'($urandom_range(0, 2));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance.
  task automatic cyc(input logic [6:0] op, input logic ir, dr, bt, input logic [2:0] st,
                     input logic irw, pcw, mr, mw, rw, input string name);
    logic [23:0] act, exp;
    Opcode      = op;
    ImemReady   = ir;
    DmemReady   = dr;
    BranchTaken = bt;
    #1;
    act = {State, ALUOp, JumpReg, Jump, Branch, RegSrc1, RegSrc2, UpperImm, MemToReg, RetAddr,
           IRWrite, PCWrite, MemRead, MemWrite, RegWrite, Trap, InstrRetired};
    exp = {st, m_sel, irw, pcw, mr, mw, rw, m_trap, m_cnt};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    Opcode      = rop();
    ImemReady   = 1'b1;
    DmemReady   = 1'b1;
    BranchTaken = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_sel   = '0;
    m_trap  = 1'b0;
    m_cnt   = '0;
  endtask

  // Expected per-cycle trace of a whole instruction given its ready delays.
  task automatic run_instr(input logic [6:0] op, input int fdel, input int mdel, input logic bt);
    logic [11:0] d;
    logic        is_br, is_ld, is_st;
    d     = dec(op);
    is_br = (op == OP_BR);
    is_ld = (op == OP_LD);
    is_st = (op == OP_ST);
    for (int i = 0; i < fdel; i++)
      cyc(rop(), 1'b0, rbit(), rbit(), 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "fetch_wait");
    cyc(rop(), 1'b1, rbit(), rbit(), 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "fetch");
    cyc(op, rbit(), rbit(), rbit(), 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
    if (!d[11]) begin
      m_trap = 1'b1;
      return;
    end
    m_sel = d[10:0];
    cyc(rop(), rbit(), rbit(), bt, 3'd2, 1'b0, is_br & bt, 1'b0, 1'b0, 1'b0, "execute");
    if (is_br) begin
      m_cnt = m_cnt + 1'b1;
      return;
    end
    if (is_ld || is_st) begin
      for (int i = 0; i < mdel; i++)
        cyc(rop(), rbit(), 1'b0, rbit(), 3'd3, 1'b0, 1'b0, is_ld, is_st, 1'b0, "mem_wait");
      cyc(rop(), rbit(), 1'b1, rbit(), 3'd3, 1'b0, is_st, is_ld, is_st, 1'b0, "mem_done");
      if (is_st) begin
        m_cnt = m_cnt + 1'b1;
        return;
      end
    end
    cyc(rop(), rbit(), rbit(), rbit(), 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "writeback");
    m_cnt = m_cnt + 1'b1;
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++)
      cyc(rop(), rbit(), rbit(), rbit(), 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "trap_hold");
  endtask

  // Reset lands in the second MEMORY wait cycle with ready high that same cycle.
  task automatic reset_mid_mem(input logic [6:0] op);
    logic [11:0] d;
    logic        is_ld;
    d     = dec(op);
    is_ld = (op == OP_LD);
    cyc(rop(), 1'b1, rbit(), rbit(), 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_fetch");
    cyc(op, rbit(), rbit(), rbit(), 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_decode");
    m_sel = d[10:0];
    cyc(rop(), rbit(), rbit(), rbit(), 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_execute");
    cyc(rop(), rbit(), 1'b0, rbit(), 3'd3, 1'b0, 1'b0, is_ld, !is_ld, 1'b0, "rst_mem_wait");
    reset_n   = 1'b0;
    DmemReady = 1'b1;
    #1;
    chk("rst_mem_pcwrite", 32'(PCWrite), 32'd0);
    chk("rst_mem_regwrite", 32'(RegWrite), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_sel   = '0;
    m_trap  = 1'b0;
    m_cnt   = '0;
    cyc(rop(), 1'b0, 1'b1, rbit(), 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_after_wait");
    run_instr(OP_R, 0, 0, 1'b0);
  endtask

  initial begin
    logic [16:0] act, exp;
    int          k;

    tbl[0]  = mk(OP_R,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(OP_R,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(OP_R,  0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 2, 0);
    tbl[3]  = mk(OP_R,  0, 0, 0, 4, 0, 1, 0, 0, 1, 0, 2, 0);
    tbl[4]  = mk(OP_BR, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0);
    tbl[5]  = mk(OP_BR, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 2, 0);
    tbl[6]  = mk(OP_BR, 0, 0, 1, 2, 0, 1, 0, 0, 0, 1, 1, 0);
    tbl[7]  = mk(OP_BR, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2, 1, 0);
    tbl[8]  = mk(OP_BR, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 1, 0);
    tbl[9]  = mk(OP_BR, 0, 0, 0, 2, 0, 0, 0, 0, 0, 2, 1, 0);
    tbl[10] = mk(OP_LD, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3, 1, 0);
    tbl[11] = mk(OP_LD, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3, 1, 0);
    tbl[12] = mk(OP_LD, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3, 0, 1);
    tbl[13] = mk(OP_LD, 0, 0, 0, 3, 0, 0, 1, 0, 0, 3, 0, 1);
    tbl[14] = mk(OP_LD, 0, 0, 0, 3, 0, 0, 1, 0, 0, 3, 0, 1);
    tbl[15] = mk(OP_LD, 0, 0, 0, 3, 0, 0, 1, 0, 0, 3, 0, 1);
    tbl[16] = mk(OP_LD, 0, 1, 0, 3, 0, 0, 1, 0, 0, 3, 0, 1);
    tbl[17] = mk(OP_LD, 0, 0, 0, 4, 0, 1, 0, 0, 1, 3, 0, 1);
    tbl[18] = mk(OP_ST, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4, 0, 1);
    tbl[19] = mk(OP_ST, 0, 0, 0, 1, 1, 0, 0, 0, 0, 4, 0, 1);
    tbl[20] = mk(OP_ST, 0, 0, 0, 2, 0, 0, 0, 0, 0, 4, 0, 0);
    tbl[21] = mk(OP_ST, 0, 1, 0, 3, 0, 1, 0, 1, 0, 4, 0, 0);
    tbl[22] = mk(OP_ST, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0, 0);

    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC};

    reset_n     = 1'b0;
    Opcode      = '0;
    ImemReady   = 1'b0;
    DmemReady   = 1'b0;
    BranchTaken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed program: R-type, branch taken/not taken, load with 3 waits, store.
    for (int i = 0; i < 23; i++) begin
      Opcode      = tbl[i].op;
      ImemReady   = tbl[i].ir;
      DmemReady   = tbl[i].dr;
      BranchTaken = tbl[i].bt;
      #1;
      act = {State, IRWrite, PCWrite, MemRead, MemWrite, RegWrite, Trap, InstrRetired, ALUOp,
             MemToReg};
      exp = {tbl[i].st, tbl[i].irw, tbl[i].pcw, tbl[i].mr, tbl[i].mw, tbl[i].rw, 1'b0,
             tbl[i].cnt, tbl[i].alu, tbl[i].m2r};
      n_cmp++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL table row %0d: got %h required %h", i, act, exp);
      end
      @(posedge clk);
      #1;
    end

    // Illegal opcode traps after DECODE and holds until reset.
    do_reset();
    run_instr(OP_I, 0, 0, 1'b0);
    run_instr(OP_BAD, 1, 0, 1'b0);
    trap_hold(20);
    do_reset();
    run_instr(OP_JAL, 0, 0, 1'b0);

    // Fetch that never completes.
    do_reset();
    for (int i = 0; i < 15; i++)
      cyc(rop(), 1'b0, rbit(), rbit(), 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "fetch_timeout");
    m_trap = 1'b1;
    trap_hold(3);

    // Store whose data ready never arrives: trap 15 cycles after MEMORY entry.
    do_reset();
    cyc(rop(), 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "st_to_fetch");
    cyc(OP_ST, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "st_to_decode");
    m_sel = dec(OP_ST) & 12'h7ff;
    cyc(rop(), 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "st_to_execute");
    for (int i = 0; i < 15; i++)
      cyc(rop(), rbit(), 1'b0, rbit(), 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "st_to_mem_wait");
    m_trap = 1'b1;
    trap_hold(3);

    // Ready arriving on the last allowed cycle wins over the timeout.
    do_reset();
    run_instr(OP_ST, 14, 14, 1'b0);
    run_instr(OP_LD, 14, 14, 1'b0);
    run_instr(OP_R, 0, 0, 1'b0);

    // Randomized instruction stream.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      k = int'($urandom_range(0, 8));
      run_instr(ops[k], pick_delay(), pick_delay(), rbit());
    end

    // Retire counter wraps modulo 16.
    do_reset();
    for (int n = 0; n < 17; n++) run_instr(OP_LUI, 0, 0, 1'b0);
    #1;
    chk("lui_wrap_count", 32'(InstrRetired), 32'd1);

    // Reset in the middle of a data access.
    reset_mid_mem(OP_LD);
    run_instr(OP_LUI, 0, 0, 1'b0);
    reset_mid_mem(OP_ST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
